data_memory: RTL
================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: DEPTH, 32, number of 32-bit words; power of two, at least 2.
REQ-002 Parameter: LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  input  1  requester presents a transaction.
REQ-006 Port: req_ready  output  1  block can accept a transaction.
REQ-007 Port: req_write  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data.
REQ-010 Port: req_wstrb  input  4  store byte enables; bit k covers wdata[8k+7:8k].
REQ-011 Port: resp_valid  output  1  response available.
REQ-012 Port: resp_ready  input  1  requester accepts the response.
REQ-013 Port: resp_rdata  output  32  load data; 0 for stores and for errored accesses.
REQ-014 Port: resp_err  output  1  access error flag, valid while resp_valid is high.
REQ-015 Port: mem_check  output  32 x DEPTH  live memory contents, for test observation only.

Function
REQ-016 The state machine SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; write, addr, wdata and wstrb SHALL be latched at that edge.
REQ-018 Transitions: IDLE->RESP when LATENCY=1; otherwise IDLE->WAIT with a down-counter loaded to LATENCY-2, and WAIT->RESP when the counter reaches 0.
REQ-019 resp_valid SHALL rise exactly LATENCY cycles after the accepting edge and SHALL stay high, with rdata and err stable, until resp_ready is sampled high.
REQ-020 On the response handshake edge the block SHALL return to IDLE; it SHALL NOT accept a new request in that same cycle. At most one transaction is outstanding.
REQ-021 Word index = addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo DEPTH words.
REQ-022 A store SHALL update only the bytes enabled in wstrb, committing on the edge that enters RESP. A store with wstrb = 0 SHALL leave memory unchanged.
REQ-023 A load SHALL return the full addressed word as sampled on the edge that enters RESP.
REQ-024 req_valid and the request fields SHALL be ignored outside IDLE. resp_ready SHALL be ignored outside RESP.

Reset
REQ-025 While reset = 0: state = IDLE, counter = 0, all memory words = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, and req_ready = 1. This takes effect immediately, without waiting for a clock edge.
REQ-026 A reset during WAIT SHALL abandon the transaction; its store SHALL NOT commit.
REQ-027 A reset during RESP SHALL drop resp_valid immediately.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN.
- Defined: an access with addr[1:0] != 0 SHALL give resp_err = 1 and resp_rdata = 0, with no memory update, at the same latency as a normal access.
- Not defined: addr[1:0] SHALL be ignored and resp_err SHALL be tied to 0.

Verification
REQ-029 Store addr 0x8, wdata 0xDEADBEEF, wstrb 0xF, then load 0x8 -> rdata 0xDEADBEEF, err 0; resp_valid exactly 2 cycles after each accept.
REQ-030 Word holds 0xDEADBEEF; store wdata 0x11223344 with wstrb 0x5 to 0x8, then load 0x8 -> rdata 0xDE22BE44.
REQ-031 Hold resp_ready = 0 for 5 cycles with req_valid held high -> resp_valid and rdata remain stable, req_ready = 0, and no second accept occurs.
REQ-032 With DEPTH = 32, store 0xA5A5A5A5 to addr 0x80, then load 0x0 -> rdata 0xA5A5A5A5 (wrap).
REQ-033 Assert reset one cycle after accepting a store of 0x1 to 0x4, then load 0x4 -> rdata 0.
REQ-034 With DMEM_ALIGN_CHECK_EN defined, load addr 0x6 -> err 1, rdata 0. Without it, the same load returns word 1 with err 0.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: single-port word memory with a valid/ready request channel and
// a valid/ready response channel. One transaction outstanding at a time; the
// response appears LATENCY cycles after the accepting edge.
//
// Parameters:
//   DEPTH   number of 32-bit words (power of two, >= 2)
//   LATENCY accept-to-response latency in cycles (1..15)
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_addr            byte address (word index from addr[log2(DEPTH)+1:2])
//   req_wdata/req_wstrb store data and byte enables
//   resp_valid/ready    response handshake
//   resp_rdata          load data (0 for stores and errored accesses)
//   resp_err            access error
//   mem_check           live memory contents for observation
//
// Build option: DMEM_ALIGN_CHECK_EN -- when defined, accesses with
// addr[1:0] != 0 respond with resp_err = 1, rdata = 0 and do not write.
module data_memory #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_wstrb,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [DEPTH-1:0][31:0] mem_check
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state, state_next;
  logic [3:0]               cnt;
  logic                     wr_q;
  logic [AW-1:0]            idx_q;
  logic [1:0]               lsb_q;
  logic [31:0]              wdata_q;
  logic [3:0]               wstrb_q;
  logic [DEPTH-1:0][31:0]   mem;

  logic                     accept;
  logic                     enter_resp;
  logic                     acc_write;
  logic [AW-1:0]            acc_idx;
  logic [1:0]               acc_lsb;
  logic [31:0]              acc_wdata;
  logic [3:0]               acc_wstrb;
  logic [31:0]              acc_wmask;
  logic                     acc_bad;
  logic                     unused_bits;

  assign accept = (state == IDLE) && req_valid;

  // With LATENCY = 1 the accepting edge is also the commit edge, so the
  // access fields come straight from the request port in IDLE and from the
  // latched copy in WAIT.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_idx   = req_addr[AW+1:2];
      acc_lsb   = req_addr[1:0];
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_write = wr_q;
      acc_idx   = idx_q;
      acc_lsb   = lsb_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    acc_wmask = {{8{acc_wstrb[3]}}, {8{acc_wstrb[2]}},
                 {8{acc_wstrb[1]}}, {8{acc_wstrb[0]}}};
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_bad = (acc_lsb != 2'b00);
`else
  assign acc_bad = 1'b0;
`endif

  assign unused_bits = ^{req_addr[31:AW+2], acc_lsb};

  assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      lsb_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      mem        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_LOAD;
        wr_q    <= req_write;
        idx_q   <= req_addr[AW+1:2];
        lsb_q   <= req_addr[1:0];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end

      // Load data is the pre-edge word; the store merge lands on the same edge.
      if (enter_resp) begin
        if (acc_write && !acc_bad)
          mem[acc_idx] <= (mem[acc_idx] & ~acc_wmask) | (acc_wdata & acc_wmask);
        resp_rdata <= (acc_write || acc_bad) ? '0 : mem[acc_idx];
        resp_err   <= acc_bad;
      end
    end
  end

  assign mem_check = mem;

endmodule
